// File: rtl/vu_peak_ctrl.sv
// VU bar display controller: maps sample bytes to a 0..8 bar level,
// keeps a peak-hold marker with timed decay, and blanks on silence.
module vu_peak_ctrl #(
  parameter int unsigned HOLD_CYCLES    = 50000000,
  parameter int unsigned DECAY_CYCLES   = 10000000,
  parameter int unsigned TIMEOUT_CYCLES = 200000000
) (
  input  logic       clk,
  input  logic       rst_,
  input  logic [7:0] sample_i,
  input  logic       sample_valid_i,
  output logic [7:0] bar_o,
  output logic [7:0] peak_o,
  output logic [3:0] level_o,
  output logic       busy_o
);

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    DECAY
  } state_t;

  localparam logic [31:0] HOLD_LAST  = 32'(HOLD_CYCLES - 1);
  localparam logic [31:0] DECAY_LAST = 32'(DECAY_CYCLES - 1);
  localparam logic [31:0] TO_LAST    = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0] TO_MAX     = 32'(TIMEOUT_CYCLES);

  state_t      state;
  state_t      state_nxt;
  logic [3:0]  bar_level;
  logic [3:0]  bar_nxt;
  logic [3:0]  peak_level;
  logic [3:0]  peak_nxt;
  logic [31:0] hold_cnt;
  logic [31:0] hold_nxt;
  logic [31:0] dec_cnt;
  logic [31:0] dec_nxt;
  logic [31:0] sil_cnt;
  logic [31:0] sil_nxt;

  logic [3:0]  lvl;
  logic        capture;
  logic [3:0]  peak_dn;
  logic [7:0]  bar_vec;
  logic [7:0]  peak_vec;

  // Sample byte to bar level; a peak is captured at or above the marker.
  always_comb begin
    lvl = 4'd0;
    if (sample_i != 8'd0) begin
      lvl = {1'b0, sample_i[7:5]} + 4'd1;
    end
    capture = sample_valid_i && (lvl != 4'd0)
              && (lvl >= peak_level);
    peak_dn = peak_level - 4'd1;
  end

  // Bar level and silence counter; a valid sample beats the timeout.
  always_comb begin
    bar_nxt = bar_level;
    sil_nxt = sil_cnt;
    if (sample_valid_i) begin
      bar_nxt = lvl;
      sil_nxt = 32'd0;
    end else begin
      if (sil_cnt < TO_MAX) begin
        sil_nxt = sil_cnt + 32'd1;
      end
      if (sil_cnt >= TO_LAST) begin
        bar_nxt = 4'd0;
      end
    end
  end

  // Peak FSM next state; a capture overrides hold expiry and decay steps.
  always_comb begin
    state_nxt = state;
    peak_nxt  = peak_level;
    hold_nxt  = hold_cnt;
    dec_nxt   = dec_cnt;
    if (capture) begin
      state_nxt = HOLD;
      peak_nxt  = lvl;
      hold_nxt  = 32'd0;
      dec_nxt   = 32'd0;
    end else begin
      unique case (state)
        IDLE: begin
          peak_nxt = 4'd0;
          hold_nxt = 32'd0;
          dec_nxt  = 32'd0;
        end
        HOLD: begin
          if (hold_cnt == HOLD_LAST) begin
            state_nxt = DECAY;
            hold_nxt  = 32'd0;
            dec_nxt   = 32'd0;
          end else begin
            hold_nxt = hold_cnt + 32'd1;
          end
        end
        DECAY: begin
          if (dec_cnt == DECAY_LAST) begin
            dec_nxt = 32'd0;
            if (peak_dn < bar_level) begin
              state_nxt = HOLD;
              peak_nxt  = bar_level;
              hold_nxt  = 32'd0;
            end else if (peak_dn == 4'd0) begin
              state_nxt = IDLE;
              peak_nxt  = 4'd0;
            end else begin
              peak_nxt = peak_dn;
            end
          end else begin
            dec_nxt = dec_cnt + 32'd1;
          end
        end
        default: begin
          state_nxt = IDLE;
          peak_nxt  = 4'd0;
          hold_nxt  = 32'd0;
          dec_nxt   = 32'd0;
        end
      endcase
    end
  end

  // Thermometer bar and one-hot marker decoded from next-cycle levels.
  always_comb begin
    bar_vec  = 8'd0;
    peak_vec = 8'd0;
    for (int i = 0; i < 8; i++) begin
      bar_vec[i] = (4'(i) < bar_nxt);
    end
    if (peak_nxt != 4'd0) begin
      peak_vec = 8'd1 << (peak_nxt - 4'd1);
    end
  end

  // Internal state registers.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state      <= IDLE;
      bar_level  <= 4'd0;
      peak_level <= 4'd0;
      hold_cnt   <= 32'd0;
      dec_cnt    <= 32'd0;
      sil_cnt    <= 32'd0;
    end else begin
      state      <= state_nxt;
      bar_level  <= bar_nxt;
      peak_level <= peak_nxt;
      hold_cnt   <= hold_nxt;
      dec_cnt    <= dec_nxt;
      sil_cnt    <= sil_nxt;
    end
  end

  // Registered LED and status outputs.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      bar_o   <= 8'd0;
      peak_o  <= 8'd0;
      level_o <= 4'd0;
      busy_o  <= 1'b0;
    end else begin
      bar_o   <= bar_vec;
      peak_o  <= peak_vec;
      level_o <= bar_nxt;
      busy_o  <= (state_nxt == HOLD) || (state_nxt == DECAY);
    end
  end

endmodule
